// File: rtl/cache_refill_engine.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_engine
// Description : Miss-handling stage behind the cache controller. For each
//               accepted miss it optionally writes back the dirty victim line
//               word by word, then fetches the missing line one word at a
//               time (one read outstanding), assembles it and hands the full
//               line back to the controller. One miss in flight at a time.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   miss_valid/miss_ready    miss request handshake (ready only when idle)
//   miss_addr                missing access address (offset ignored)
//   victim_dirty/addr/line   victim line to write back when dirty
//   mem_req_*                word request port (valid/ready, we, addr, wdata)
//   mem_rsp_valid/data       read response, exactly one per read request
//   fill_valid/ready         assembled-line handshake
//   fill_addr/fill_line      line-aligned address and assembled line
// Build option:
//   CACHE_REFILL_CWF_EN      critical word first: reads start at the missing
//                            word and wrap around the line. Write-back order
//                            and the assembled line are unaffected.
// ============================================================================
module cache_refill_engine #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LINE_SIZE_BYTES = 64,
    parameter int OFFSET_BITS     = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_valid,
    output logic                           miss_ready,
    input  logic [ADDRESS_WIDTH-1:0]       miss_addr,
    input  logic                           victim_dirty,
    input  logic [ADDRESS_WIDTH-1:0]       victim_addr,
    input  logic [LINE_SIZE_BYTES*8-1:0]   victim_line,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_we,
    output logic [ADDRESS_WIDTH-1:0]       mem_req_addr,
    output logic [DATA_WIDTH-1:0]          mem_req_wdata,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
    output logic                           fill_valid,
    input  logic                           fill_ready,
    output logic [ADDRESS_WIDTH-1:0]       fill_addr,
    output logic [LINE_SIZE_BYTES*8-1:0]   fill_line
);

    localparam int c_WPL       = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
    localparam int c_IDX_W     = $clog2(c_WPL);
    localparam int c_BYTE_BITS = $clog2(DATA_WIDTH / 8);

    localparam logic [ADDRESS_WIDTH-1:0] c_LINE_MASK =
        ~((ADDRESS_WIDTH'(1) << OFFSET_BITS) - ADDRESS_WIDTH'(1));
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_WPL - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        RD_REQ = 3'd2,
        RD_RSP = 3'd3,
        FILL   = 3'd4
    } state_e;

    // Line storage kept as word arrays; the packed layout puts word i at
    // bits [i*DATA_WIDTH +: DATA_WIDTH], matching the flat port packing.
    typedef logic [c_WPL-1:0][DATA_WIDTH-1:0] line_t;

    state_e                    state_q, state_d;
    logic [c_IDX_W-1:0]        idx_q, idx_d;
    logic [c_IDX_W-1:0]        start_q, start_d;
    logic [ADDRESS_WIDTH-1:0]  line_base_q, line_base_d;
    logic [ADDRESS_WIDTH-1:0]  victim_base_q, victim_base_d;
    line_t                     victim_q, victim_d;
    line_t                     fill_q, fill_d;

    // Read word index: the counter counts reads issued, the start offset
    // rotates it for critical-word-first (start is 0 otherwise). Natural
    // wrap of the c_IDX_W-bit sum gives the modulo-WPL ordering.
    logic [c_IDX_W-1:0]        w_rd_word;
    logic [c_IDX_W-1:0]        w_miss_word;
    logic [ADDRESS_WIDTH-1:0]  w_wb_off;
    logic [ADDRESS_WIDTH-1:0]  w_rd_off;

    assign w_rd_word   = idx_q + start_q;
    assign w_wb_off    = ADDRESS_WIDTH'(idx_q) << c_BYTE_BITS;
    assign w_rd_off    = ADDRESS_WIDTH'(w_rd_word) << c_BYTE_BITS;

`ifdef CACHE_REFILL_CWF_EN
    assign w_miss_word = miss_addr[OFFSET_BITS-1:c_BYTE_BITS];
`else
    assign w_miss_word = '0;
`endif

    assign miss_ready = (state_q == IDLE) && !rst;
    assign fill_line  = fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            start_q       <= '0;
            line_base_q   <= '0;
            victim_base_q <= '0;
            victim_q      <= '0;
            fill_q        <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            start_q       <= start_d;
            line_base_q   <= line_base_d;
            victim_base_q <= victim_base_d;
            victim_q      <= victim_d;
            fill_q        <= fill_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        start_d       = start_q;
        line_base_d   = line_base_q;
        victim_base_d = victim_base_q;
        victim_d      = victim_q;
        fill_d        = fill_q;

        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        fill_valid    = 1'b0;
        fill_addr     = '0;

        case (state_q)
            IDLE: begin
                if (miss_valid && miss_ready) begin
                    line_base_d   = miss_addr & c_LINE_MASK;
                    victim_base_d = victim_addr & c_LINE_MASK;
                    victim_d      = victim_line;
                    start_d       = w_miss_word;
                    idx_d         = '0;
                    state_d       = victim_dirty ? WB : RD_REQ;
                end
            end

            WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = victim_base_q + w_wb_off;
                mem_req_wdata = victim_q[idx_q];
                if (mem_req_ready) begin
                    // Wraps to 0 after the last beat, ready for the reads.
                    idx_d = idx_q + c_IDX_ONE;
                    if (idx_q == c_LAST_IDX) begin
                        state_d = RD_REQ;
                    end
                end
            end

            RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = line_base_q + w_rd_off;
                if (mem_req_ready) begin
                    state_d = RD_RSP;
                end
            end

            RD_RSP: begin
                if (mem_rsp_valid) begin
                    fill_d[w_rd_word] = mem_rsp_data;
                    idx_d             = idx_q + c_IDX_ONE;
                    state_d           = (idx_q == c_LAST_IDX) ? FILL : RD_REQ;
                end
            end

            FILL: begin
                fill_valid = 1'b1;
                fill_addr  = line_base_q;
                if (fill_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/cache_refill_engine.md
# cache_refill_engine

Miss-handling stage directly downstream of `cache_controller` in the 4-way set-associative cache. On a miss it:
- writes back the dirty victim line to memory, if there is one;
- fetches the missing 64-byte line one word at a time over a simple request/response memory port;
- assembles the words into a full line and hands it back to the controller for installation.

There is one miss in flight at a time.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, memory word width
- `LINE_SIZE_BYTES`, 64, cache line size; words per line `WPL = LINE_SIZE_BYTES*8/DATA_WIDTH` (16)
- `OFFSET_BITS`, 6, log2(`LINE_SIZE_BYTES`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `miss_valid`  in  1  controller requests a refill
- `miss_ready`  out  1  engine idle, can accept a miss
- `miss_addr`  in  ADDRESS_WIDTH  missing access address (offset ignored)
- `victim_dirty`  in  1  victim line must be written back
- `victim_addr`  in  ADDRESS_WIDTH  victim line address (offset ignored)
- `victim_line`  in  LINE_SIZE_BYTES*8  victim data, word i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `mem_req_valid`  out  1  memory request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_we`  out  1  1 = write, 0 = read
- `mem_req_addr`  out  ADDRESS_WIDTH  word-aligned byte address
- `mem_req_wdata`  out  DATA_WIDTH  write data
- `mem_rsp_valid`  in  1  read data valid
- `mem_rsp_data`  in  DATA_WIDTH  read data
- `fill_valid`  out  1  assembled line available
- `fill_ready`  in  1  controller takes line
- `fill_addr`  out  ADDRESS_WIDTH  line-aligned address of filled line
- `fill_line`  out  LINE_SIZE_BYTES*8  assembled line, same word packing as `victim_line`

## Operation
- FSM states: IDLE, WB, RD_REQ, RD_RSP, FILL.
- `miss_ready = (state==IDLE) && !rst`.

Miss acceptance:
- A miss is accepted on `miss_valid && miss_ready`.
- On acceptance the engine registers:
  - line base `miss_addr` with the low `OFFSET_BITS` cleared;
  - victim base, cleared the same way;
  - `victim_line`;
  - `victim_dirty`.
- The word counter `idx` is cleared.
- Next state is WB if `victim_dirty`, else RD_REQ.

WB (victim write-back):
- Drives `mem_req_valid=1`, `mem_req_we=1`.
- `mem_req_addr = victim_base + idx*(DATA_WIDTH/8)`; `mem_req_wdata` = registered victim word `idx`.
- On each accepted beat (`mem_req_valid && mem_req_ready`), `idx` increments.
- After beat `WPL-1`: `idx` clears, next state is RD_REQ.
- Writes produce no response.

RD_REQ (issue read):
- Drives `mem_req_valid=1`, `mem_req_we=0`.
- `mem_req_addr = line_base + idx*(DATA_WIDTH/8)`.
- On acceptance, next state is RD_RSP.

RD_RSP (collect read data):
- On `mem_rsp_valid`, `mem_rsp_data` is stored into fill word `idx`.
- If this was the last word, next state is FILL; otherwise `idx` advances and next state is RD_REQ.
- At most one read is outstanding. `mem_rsp_valid` is ignored in every other state.

FILL:
- `fill_valid=1`; `fill_addr` = line base.
- On `fill_valid && fill_ready`, next state is IDLE.

Stability and defaults:
- `mem_req_addr`, `mem_req_we` and `mem_req_wdata` are held stable while `mem_req_valid && !mem_req_ready`.
- `fill_addr` and `fill_line` are held stable while `fill_valid`.
- `mem_req_wdata` is 0 during reads.
- `mem_req_valid` is 0 in IDLE, RD_RSP and FILL.
- `idx` wraps modulo `WPL`; the address arithmetic is `ADDRESS_WIDTH` bits, and carry out of the offset field is impossible by construction.

## Timing
- Reset values (synchronous, on the first edge with `rst` high):
  - state IDLE;
  - `miss_ready=0` while `rst` is high, 1 on the cycle after release;
  - `mem_req_valid`, `mem_req_we`, `mem_req_addr`, `mem_req_wdata`, `fill_valid`, `fill_addr` and `fill_line` all 0.
- Miss accepted at cycle T. The first memory request is driven at T+1.
- Clean miss, with `mem_req_ready=1` and each response exactly one cycle after acceptance:
  - word k requested at T+1+2k, response at T+2+2k;
  - `fill_valid` at T+2·WPL+1 (T+33).
- Dirty miss, same memory behaviour:
  - write beats T+1..T+WPL;
  - first read at T+WPL+1;
  - `fill_valid` at T+3·WPL+1 (T+49).
- FILL lasts until `fill_ready`. `miss_ready` rises the cycle after the fill handshake, so back-to-back misses have a minimum gap of one cycle.
- Reset mid-operation:
  - the current transfer is abandoned and the state returns to IDLE;
  - late `mem_rsp_valid` is ignored;
  - partial data is never presented on `fill_valid`.
- `miss_valid` while not ready has no effect; the controller holds its request.

## Configuration
- `CACHE_REFILL_CWF_EN` (critical word first):
  - Defined: read order starts at word `miss_addr[OFFSET_BITS-1:$clog2(DATA_WIDTH/8)]` and wraps modulo `WPL`, for `WPL` reads in total. Write-back order is unchanged.
  - Undefined: reads start at word 0.
  - In both cases each word is stored at its own index, so `fill_line` is identical. Only the `mem_req_addr` sequence differs.

## Test plan
- Clean miss: `miss_addr=0x0000_1234`, memory returns `0xA000_0000+k` for word k → reads to 0x1200..0x123C in order; `fill_addr=0x1200`; `fill_line` word k = `0xA000_0000+k`; `fill_valid` at T+33.
- Dirty miss: `victim_addr=0x0008_0040`, victim word i = i → 16 writes to 0x80040..0x8007C with wdata 0..15, then reads; `fill_valid` at T+49.
- Backpressure: `mem_req_ready` low for 3 cycles per beat; responses delayed 5 cycles; `fill_ready` low for 4 cycles → request fields stable while stalled; same `fill_line`; one fill handshake; `miss_ready` stays 0 throughout.
- Reset at read word 7, with a response arriving the cycle after reset → IDLE; `fill_valid` stays 0; `miss_ready=1` after release; the next miss completes correctly.
- `CACHE_REFILL_CWF_EN` defined, `miss_addr=0x1234` → first read 0x1234, then 0x1238, 0x123C, 0x1200 … 0x1230; `fill_line` equal to the non-CWF run.
- Spurious `mem_rsp_valid` in IDLE or WB → no state or data change.
